param_rate_divider: RTL and testbench
=====================================

PARAM_RATE_DIVIDER -- requirements
Module: param_rate_divider

Interface
- REQ-001: Parameter WIDTH, default 32, SHALL set the counter and period width in bits (min 2).
- REQ-002: Parameter CHANNELS, default 4, SHALL set the number of independent divider channels (min 1).
- REQ-003: Parameter CHAN_W, default 2, SHALL set the wr_chan width (>= clog2(CHANNELS), min 1).
- REQ-004: clock  input  1  SHALL be the single clock; all state updates on its rising edge.
- REQ-005: reset  input  1  SHALL be the synchronous, active-high reset.
- REQ-006: wr_en  input  1  SHALL qualify a period/mode write for one cycle.
- REQ-007: wr_chan  input  CHAN_W  SHALL select the channel written.
- REQ-008: wr_period  input  WIDTH  SHALL carry the period N as an unsigned cycle count (not two's complement).
- REQ-009: wr_oneshot  input  1  SHALL select the mode: 1 = one-shot, 0 = periodic.
- REQ-010: ch_enable  input  CHANNELS  SHALL be the per-channel count enable, bit i for channel i.
- REQ-011: out_pulse  output  CHANNELS  SHALL be the registered one-cycle terminal-count pulse per channel.
- REQ-012: busy  output  CHANNELS  SHALL be high while channel i is armed.

Function
- REQ-013: Each channel SHALL hold period[WIDTH], cnt[WIDTH], oneshot, armed and pulse registers; channels SHALL be fully independent.
- REQ-014: A write (wr_en=1, wr_chan<CHANNELS) SHALL at that edge load period<=wr_period, oneshot<=wr_oneshot, cnt<=wr_period-1 and armed<=(wr_period!=0), and clear the channel's pulse.
- REQ-015: A write with wr_chan>=CHANNELS SHALL be ignored; no state changes.
- REQ-016: An armed, enabled channel with cnt!=0 SHALL decrement cnt by 1 per edge and drive pulse 0.
- REQ-017: An armed, enabled channel with cnt==0 SHALL set pulse to 1 for exactly the next cycle. Periodic mode: reload cnt<=period-1. One-shot mode: clear armed, hold cnt at 0.
- REQ-018: Latency: with enable held high, the first out_pulse SHALL appear N cycles after the write edge, then every N cycles in periodic mode.
- REQ-019: N=1 periodic SHALL pulse every cycle from the first edge after the write.
- REQ-020: N=0 SHALL disarm the channel; it SHALL never pulse and busy SHALL stay 0.
- REQ-021: With ch_enable[i]=0, cnt and armed SHALL hold and out_pulse[i] SHALL be 0; counting SHALL resume from the held value when enable returns.
- REQ-022: A write landing on the same edge as the channel's terminal count SHALL win: no pulse, cnt reloaded from the new value.
- REQ-023: A write SHALL take effect whether ch_enable is high or low.
- REQ-024: No arithmetic SHALL wrap: cnt-1 is evaluated only when cnt!=0, and period-1 only when period!=0; N=2^WIDTH-1 SHALL be supported.
- REQ-025: busy[i] SHALL equal armed[i].

Reset
- REQ-026: reset=1 SHALL at the next edge clear every channel: period=0, cnt=0, oneshot=0, armed=0, out_pulse=0, busy=0.
- REQ-027: reset SHALL take priority over a simultaneous write; mid-count reset SHALL abort the count, with no pulse in the following cycle.
- REQ-028: After reset, no channel SHALL pulse until written with a nonzero period.

Verification
- REQ-029: Write ch0 N=5 periodic, enable high -> out_pulse[0] high 5 cycles after the write edge, then every 5 cycles, each pulse one cycle wide.
- REQ-030: Write ch1 N=3 one-shot -> single pulse 3 cycles after the write; busy[1] drops in the same cycle the pulse rises; no further pulses.
- REQ-031: ch2 N=4, drop enable for 2 cycles mid-count -> pulse delayed by exactly 2 cycles; N=1 on ch3 -> continuous pulses.
- REQ-032: Rewrite ch0 with N=7 on its terminal-count edge -> no pulse; next pulse 7 cycles later. Write N=0 -> busy 0, never pulses.
- REQ-033: WIDTH=4, N=15 -> pulse period 15 with no wrap. Write wr_chan=CHANNELS -> no change. Assert reset mid-count -> all outputs 0 next cycle, no pulse until rewritten.

Source files
------------

// File: rtl/param_rate_divider.sv
// Independent programmable per-channel rate dividers; a period-N write produces a registered one-cycle pulse N edges later.
// No backpressure: writes always land (on an in-range channel), and ch_enable freezes a channel's count in place.
module param_rate_divider #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int CHAN_W   = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [CHAN_W-1:0]   wr_chan,
  input  logic [WIDTH-1:0]    wr_period,
  input  logic                wr_oneshot,
  input  logic [CHANNELS-1:0] ch_enable,
  output logic [CHANNELS-1:0] out_pulse,
  output logic [CHANNELS-1:0] busy
);

  logic wr_chan_ok;
  assign wr_chan_ok = (32'(wr_chan) < 32'(CHANNELS));

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] cnt_q;
    logic             oneshot_q;
    logic             armed_q;
    logic             pulse_q;
    logic             wr_hit;

    assign wr_hit = wr_en && wr_chan_ok && (wr_chan == CHAN_W'(i));

    // A write outranks a terminal count on the same edge; every decrement is guarded against wrap.
    always_ff @(posedge clock) begin
      if (reset) begin
        period_q  <= '0;
        cnt_q     <= '0;
        oneshot_q <= 1'b0;
        armed_q   <= 1'b0;
        pulse_q   <= 1'b0;
      end else if (wr_hit) begin
        period_q  <= wr_period;
        oneshot_q <= wr_oneshot;
        cnt_q     <= (wr_period != '0) ? wr_period - WIDTH'(1) : '0;
        armed_q   <= (wr_period != '0);
        pulse_q   <= 1'b0;
      end else if (armed_q && ch_enable[i]) begin
        if (cnt_q != '0) begin
          cnt_q   <= cnt_q - WIDTH'(1);
          pulse_q <= 1'b0;
        end else begin
          pulse_q <= 1'b1;
          if (oneshot_q) begin
            armed_q <= 1'b0;
          end else begin
            cnt_q <= (period_q != '0) ? period_q - WIDTH'(1) : '0;
          end
        end
      end else begin
        pulse_q <= 1'b0;
      end
    end

    assign out_pulse[i] = pulse_q;
    assign busy[i]      = armed_q;
  end

endmodule

// File: tb/tb_param_rate_divider.sv
// Directed bench for param_rate_divider at WIDTH=4, CHANNELS=3 so that N=15 and an out-of-range channel are reachable.
module tb_param_rate_divider;

  localparam int WIDTH    = 4;
  localparam int CHANNELS = 3;
  localparam int CHAN_W   = 2;

  logic                clock = 1'b0;
  logic                reset;
  logic                wr_en;
  logic [CHAN_W-1:0]   wr_chan;
  logic [WIDTH-1:0]    wr_period;
  logic                wr_oneshot;
  logic [CHANNELS-1:0] ch_enable;
  logic [CHANNELS-1:0] out_pulse;
  logic [CHANNELS-1:0] busy;

  int n_tests = 0;
  int n_fail  = 0;

  param_rate_divider #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CHAN_W(CHAN_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_chan    (wr_chan),
    .wr_period  (wr_period),
    .wr_oneshot (wr_oneshot),
    .ch_enable  (ch_enable),
    .out_pulse  (out_pulse),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [CHAN_W-1:0] ch, input logic [WIDTH-1:0] n, input logic os);
    wr_en = 1'b1; wr_chan = ch; wr_period = n; wr_oneshot = os;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_chan = '0; wr_period = '0; wr_oneshot = 1'b0;
    ch_enable = '1;

    // Reset with a simultaneous write: reset wins.
    wr_en = 1'b1; wr_chan = 2'd0; wr_period = 4'd2;
    tick();
    wr_en = 1'b0; reset = 1'b0;
    chk("reset_pulse", 32'(out_pulse), 32'h0);
    chk("reset_busy",  32'(busy),      32'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("post_reset_pulse", 32'(out_pulse), 32'h0);
      chk("post_reset_busy",  32'(busy),      32'h0);
    end

    // ch0 N=5 periodic.
    wr(2'd0, 4'd5, 1'b0);
    chk("p5_wr_busy", 32'(busy), 32'h1);
    chk("p5_wr_pulse", 32'(out_pulse), 32'h0);
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk("p5_pulse", 32'(out_pulse), (k % 5 == 0) ? 32'h1 : 32'h0);
    end

    // ch1 N=3 one-shot.
    do_reset();
    wr(2'd1, 4'd3, 1'b1);
    chk("os3_wr_busy", 32'(busy), 32'h2);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("os3_pulse", 32'(out_pulse), (k == 3) ? 32'h2 : 32'h0);
      chk("os3_busy",  32'(busy),      (k < 3)  ? 32'h2 : 32'h0);
    end

    // ch2 N=4 with enable dropped for two edges mid-count.
    do_reset();
    wr(2'd2, 4'd4, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      ch_enable = (k == 3 || k == 4) ? 3'b011 : 3'b111;
      tick();
      chk("en_gap_pulse", 32'(out_pulse), (k == 6) ? 32'h4 : 32'h0);
      chk("en_gap_busy",  32'(busy),      32'h4);
    end
    ch_enable = '1;

    // ch2 N=1: pulse on every edge after the write.
    wr(2'd2, 4'd1, 1'b0);
    chk("n1_wr_pulse", 32'(out_pulse), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("n1_pulse", 32'(out_pulse), 32'h4);
    end

    // Rewrite ch0 on its terminal-count edge, then disarm with N=0.
    do_reset();
    wr(2'd0, 4'd3, 1'b0);
    tick(); chk("tc_pre1", 32'(out_pulse), 32'h0);
    tick(); chk("tc_pre2", 32'(out_pulse), 32'h0);
    wr(2'd0, 4'd7, 1'b0);
    chk("tc_wr_pulse", 32'(out_pulse), 32'h0);
    chk("tc_wr_busy",  32'(busy),      32'h1);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("tc_n7_pulse", 32'(out_pulse), (k == 7) ? 32'h1 : 32'h0);
    end
    wr(2'd0, 4'd0, 1'b0);
    chk("n0_busy", 32'(busy), 32'h0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("n0_pulse", 32'(out_pulse), 32'h0);
      chk("n0_busy_hold", 32'(busy), 32'h0);
    end

    // ch0 N=15 (max for WIDTH=4), with an out-of-range write part way through.
    do_reset();
    wr(2'd0, 4'd15, 1'b0);
    for (int k = 1; k <= 45; k++) begin
      if (k == 31) begin
        wr_en = 1'b1; wr_chan = 2'd3; wr_period = 4'd1; wr_oneshot = 1'b0;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      chk("n15_pulse", 32'(out_pulse), (k % 15 == 0) ? 32'h1 : 32'h0);
      if (k >= 31) chk("oor_busy", 32'(busy), 32'h1);
    end
    wr_en = 1'b0;

    // Reset landing on ch1's terminal-count edge while ch0 also counts.
    do_reset();
    wr(2'd0, 4'd9, 1'b0);
    wr(2'd1, 4'd3, 1'b0);
    tick(); tick();
    chk("mid_busy_pre", 32'(busy), 32'h3);
    do_reset();
    chk("mid_reset_pulse", 32'(out_pulse), 32'h0);
    chk("mid_reset_busy",  32'(busy),      32'h0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("mid_after_pulse", 32'(out_pulse), 32'h0);
      chk("mid_after_busy",  32'(busy),      32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
